prog_fetch_ctrl: RTL and testbench
==================================

Name: prog_fetch_ctrl

Overview:
Instruction fetch sequencer for the program ROM (8-bit address, chip-select, 17-bit combinational instruction output). It owns the program counter and drives ROM address and chip-select. It captures each instruction into a one-entry instruction register and hands it to decode over a valid/ready handshake. It supports start, halt, redirect (jump/branch) and end-of-program wrap.

Parameters:
ADDR_W, 8, program address width
INSTR_W, 17, instruction width
RESET_PC, 8'h00, PC loaded by start from IDLE
PC_MAX, 8'h21, last valid program address; PC wraps from PC_MAX to RESET_PC

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: IDLE->RUN from RESET_PC; HALT->RUN from current PC
halt_req  in  1  stop fetching after current cycle
redirect_valid  in  1  load PC with redirect_addr, flush IR
redirect_addr  in  ADDR_W  redirect target
pm_addr  out  ADDR_W  ROM address, always equal to PC
pm_cs  out  1  ROM chip-select, high only in a fetch cycle
pm_instr  in  INSTR_W  ROM instruction, combinational from pm_addr/pm_cs
ir_valid  out  1  ir_instr/ir_pc hold an instruction
ir_ready  in  1  decode accepts the IR this cycle
ir_instr  out  INSTR_W  captured instruction
ir_pc  out  ADDR_W  address of ir_instr
busy  out  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On assertion, at any time including mid-fetch: state=IDLE, PC=RESET_PC, ir_valid=0, ir_instr=0, ir_pc=0, busy=0, pm_cs=0.
- States: IDLE, RUN, HALT. Registered state.
- IDLE: pm_cs=0. redirect_valid and halt_req are ignored. start -> RUN with PC=RESET_PC.
- RUN, fetch condition: no redirect AND (ir_valid==0 OR ir_ready==1).
- RUN, fetch cycle: pm_cs=1 combinationally. At the edge: ir_instr<=pm_instr, ir_pc<=PC, ir_valid<=1, and PC<=PC+1. If PC==PC_MAX, PC<=RESET_PC instead.
- RUN, stall (ir_valid=1, ir_ready=0): pm_cs=0; PC, ir_instr, ir_pc held stable.
- RUN, no fetch but ir_ready=1 and ir_valid=1: ir_valid<=0.
- Redirect (RUN only) has priority over fetch. That cycle pm_cs=0; PC<=redirect_addr; ir_valid<=0, which drops the pending IR even if not accepted.
- Redirect latency: first new instruction has ir_valid=1 two edges after the redirect edge.
- halt_req (RUN only): this cycle's fetch or accept proceeds normally, then state<=HALT.
- halt_req with redirect_valid in the same cycle: redirect applies (PC load, flush) and state goes to HALT.
- HALT: pm_cs=0; PC frozen. The pending IR stays valid until accepted; ir_ready=1 clears ir_valid. start -> RUN at current PC. start together with halt_req in RUN: halt wins.
- Start-up latency: start at edge k gives ir_valid=1 at edge k+2, with ir_pc=RESET_PC.
- Steady state: one instruction per clock while ir_ready=1.
- busy = (state==RUN).
- pm_addr = PC at all times. The ROM outputs 0 when pm_cs=0; the block never samples pm_instr when pm_cs=0.
- PC arithmetic: ADDR_W-bit unsigned, with explicit wrap at PC_MAX. If PC_MAX=8'hFF this equals natural overflow.
- redirect_addr > PC_MAX is loaded as-is. Increment from it is plain +1 until the next wrap.

Decomposition:
- Shared package fetch_pkg: ADDR_W, INSTR_W, RESET_PC, PC_MAX constants; state enum {IDLE, RUN, HALT}.
- Single module. No sub-module is warranted: PC, FSM and the IR register are tightly coupled. The ROM is instantiated alongside it at the top level, not inside it.

Test Plan:
- Cold start: reset, start pulse, ir_ready=1.
  -> ir_valid rises 2 edges after start.
  -> ir_pc sequence 00,01,02; ir_instr for 01 = 17'b01000000000000100.
- Backpressure: ir_ready=0 for 3 cycles while ir_valid=1 at ir_pc=03.
  -> pm_cs=0, ir_pc/ir_instr stable, PC=04 held.
  -> on release, next ir_pc=04 (17'b00001000000010000), no skip or duplicate.
- Redirect to 8'h11 mid-stream.
  -> ir_valid=0 the next cycle.
  -> next valid ir_pc=11, ir_instr=17'b01100000000101100, then ir_pc=12.
- Halt then resume: halt_req at ir_pc=05, with pending IR not accepted.
  -> pm_cs=0, IR held until ir_ready, busy=0.
  -> start -> fetch resumes at 06; simultaneous halt_req+redirect to 8'h20 -> HALT, resume fetches 20.
- Wrap: run through PC_MAX=21.
  -> ir_pc sequence 20,21,00,01 (ir_instr at 21 = 17'b00011100001011000).
- Async reset mid-RUN, asserted between edges.
  -> all outputs go to reset values immediately.
  -> start again begins at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared constants, state encoding and PC-step helper for the fetch sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 17;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  localparam logic [ADDR_W-1:0] PC_MAX = 8'h21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Sequential PC step: wraps explicitly at PC_MAX. Any address above PC_MAX
  // (reachable only through a redirect) just counts up until natural overflow.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    if (pc == PC_MAX) begin
      return RESET_PC;
    end
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// prog_fetch_ctrl
// Program-ROM fetch sequencer: owns the PC, drives ROM address/chip-select,
// captures each instruction into a one-entry IR handed to decode by
// valid/ready. Supports start, halt, redirect and end-of-program wrap.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module prog_fetch_ctrl
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic               pm_cs,
  input  logic [INSTR_W-1:0] pm_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               busy
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_ir_valid;
  logic [INSTR_W-1:0]  r_ir_instr;
  logic [ADDR_W-1:0]   r_ir_pc;
  logic                w_fetch;

  // A fetch happens in RUN when no redirect is pending and the IR is free or
  // being drained this cycle. Redirect suppresses the ROM access entirely.
  always_comb begin
    w_fetch = (r_state == RUN) && !redirect_valid && (!r_ir_valid || ir_ready);
  end

  assign pm_cs    = w_fetch;
  assign pm_addr  = r_pc;
  assign ir_valid = r_ir_valid;
  assign ir_instr = r_ir_instr;
  assign ir_pc    = r_ir_pc;
  assign busy     = (r_state == RUN);

  // Sequencer FSM with PC and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_ir_valid <= 1'b0;
      r_ir_instr <= '0;
      r_ir_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Redirect and halt are meaningless before the program starts.
          if (start) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
          end
        end

        RUN: begin
          if (redirect_valid) begin
            // Flush drops the pending IR even if decode never took it.
            r_pc       <= redirect_addr;
            r_ir_valid <= 1'b0;
          end else if (w_fetch) begin
            r_ir_instr <= pm_instr;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= next_pc(r_pc);
          end
          // Otherwise IR is stalled by decode: everything holds.
          // Halt lets this cycle's action finish, and beats a concurrent start.
          if (halt_req) begin
            r_state <= HALT;
          end
        end

        HALT: begin
          // PC frozen; the pending IR can still drain to decode.
          if (r_ir_valid && ir_ready) begin
            r_ir_valid <= 1'b0;
          end
          if (start) begin
            r_state <= RUN;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prog_fetch_ctrl
// Directed self-checking bench for prog_fetch_ctrl with a behavioural ROM.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic [7:0]  pm_addr;
  logic        pm_cs;
  logic [16:0] pm_instr;
  logic        ir_valid;
  logic        ir_ready;
  logic [16:0] ir_instr;
  logic [7:0]  ir_pc;
  logic        busy;

  int errors;
  int checks;

  prog_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .pm_addr        (pm_addr),
    .pm_cs          (pm_cs),
    .pm_instr       (pm_instr),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_instr       (ir_instr),
    .ir_pc          (ir_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program ROM contents: a few known words, the rest derived from address.
  function automatic logic [16:0] rom_word(input logic [7:0] a);
    case (a)
      8'h01:   return 17'b01000000000000100;
      8'h04:   return 17'b00001000000010000;
      8'h11:   return 17'b01100000000101100;
      8'h21:   return 17'b00011100001011000;
      default: return {1'b1, a, 8'h5A};
    endcase
  endfunction

  assign pm_instr = pm_cs ? rom_word(pm_addr) : 17'd0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic [7:0] pc);
    chk_val({tag, ".valid"}, {31'd0, ir_valid}, 32'd1);
    chk_val({tag, ".pc"}, {24'd0, ir_pc}, {24'd0, pc});
    chk_val({tag, ".instr"}, {15'd0, ir_instr}, {15'd0, rom_word(pc)});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start = 1'b0;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;
    ir_ready = 1'b0;

    // Reset state
    step(); step();
    chk_val("rst.valid", {31'd0, ir_valid}, 32'd0);
    chk_val("rst.busy", {31'd0, busy}, 32'd0);
    chk_val("rst.cs", {31'd0, pm_cs}, 32'd0);
    chk_val("rst.addr", {24'd0, pm_addr}, 32'h00);
    chk_val("rst.irpc", {24'd0, ir_pc}, 32'h00);
    chk_val("rst.instr", {15'd0, ir_instr}, 32'd0);
    rst_n = 1'b1;
    // IDLE ignores redirect/halt
    redirect_valid = 1'b1; redirect_addr = 8'h40; halt_req = 1'b1;
    step();
    redirect_valid = 1'b0; halt_req = 1'b0;
    chk_val("idle.addr", {24'd0, pm_addr}, 32'h00);
    chk_val("idle.busy", {31'd0, busy}, 32'd0);

    // Cold start
    start = 1'b1; ir_ready = 1'b1;
    step();
    start = 1'b0;
    chk_val("cold.busy", {31'd0, busy}, 32'd1);
    chk_val("cold.valid1", {31'd0, ir_valid}, 32'd0);
    chk_val("cold.cs", {31'd0, pm_cs}, 32'd1);
    step(); chk_ir("cold0", 8'h00);
    step(); chk_ir("cold1", 8'h01);
    step(); chk_ir("cold2", 8'h02);
    step(); chk_ir("cold3", 8'h03);

    // Backpressure at ir_pc=03
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_val("bp.cs", {31'd0, pm_cs}, 32'd0);
      step();
      chk_ir("bp.hold", 8'h03);
      chk_val("bp.addr", {24'd0, pm_addr}, 32'h04);
    end
    ir_ready = 1'b1;
    #1; chk_val("bp.rel_cs", {31'd0, pm_cs}, 32'd1);
    step(); chk_ir("bp4", 8'h04);
    step(); chk_ir("bp5", 8'h05);

    // Halt with pending IR not accepted
    ir_ready = 1'b0; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk_val("halt.busy", {31'd0, busy}, 32'd0);
    chk_val("halt.cs", {31'd0, pm_cs}, 32'd0);
    chk_val("halt.addr", {24'd0, pm_addr}, 32'h06);
    step(); chk_ir("halt.hold", 8'h05);
    ir_ready = 1'b1;
    step();
    chk_val("halt.drain", {31'd0, ir_valid}, 32'd0);
    chk_val("halt.cs2", {31'd0, pm_cs}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_val("resume.busy", {31'd0, busy}, 32'd1);
    step(); chk_ir("resume6", 8'h06);
    step(); chk_ir("resume7", 8'h07);

    // Halt + redirect together, start in same cycle is overridden
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h20; start = 1'b1;
    #1; chk_val("hr.cs", {31'd0, pm_cs}, 32'd0);
    step();
    halt_req = 1'b0; redirect_valid = 1'b0; start = 1'b0;
    chk_val("hr.busy", {31'd0, busy}, 32'd0);
    chk_val("hr.valid", {31'd0, ir_valid}, 32'd0);
    chk_val("hr.addr", {24'd0, pm_addr}, 32'h20);
    step();
    chk_val("hr.hold", {24'd0, pm_addr}, 32'h20);
    start = 1'b1;
    step();
    start = 1'b0;

    // Wrap through PC_MAX
    step(); chk_ir("wrap20", 8'h20);
    step(); chk_ir("wrap21", 8'h21);
    step(); chk_ir("wrap00", 8'h00);
    step(); chk_ir("wrap01", 8'h01);

    // Redirect mid-stream to 11 (IR pending is dropped)
    redirect_valid = 1'b1; redirect_addr = 8'h11;
    #1; chk_val("rd.cs", {31'd0, pm_cs}, 32'd0);
    step();
    redirect_valid = 1'b0;
    chk_val("rd.valid", {31'd0, ir_valid}, 32'd0);
    chk_val("rd.addr", {24'd0, pm_addr}, 32'h11);
    step(); chk_ir("rd11", 8'h11);
    step(); chk_ir("rd12", 8'h12);

    // Redirect beyond PC_MAX counts with plain +1 and natural overflow
    redirect_valid = 1'b1; redirect_addr = 8'hFE;
    step();
    redirect_valid = 1'b0;
    step(); chk_ir("hiFE", 8'hFE);
    step(); chk_ir("hiFF", 8'hFF);
    step(); chk_ir("hi00", 8'h00);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_val("arst.valid", {31'd0, ir_valid}, 32'd0);
    chk_val("arst.busy", {31'd0, busy}, 32'd0);
    chk_val("arst.cs", {31'd0, pm_cs}, 32'd0);
    chk_val("arst.addr", {24'd0, pm_addr}, 32'h00);
    chk_val("arst.irpc", {24'd0, ir_pc}, 32'h00);
    chk_val("arst.instr", {15'd0, ir_instr}, 32'd0);
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_ir("restart0", 8'h00);
    step(); chk_ir("restart1", 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
